// File: rtl/bsg_mem_rmw_pkg.sv
// Shared types and helpers for the byte-masked read-modify-write RAM wrapper.
package bsg_mem_rmw_pkg;

    typedef enum logic [0:0] {
        eIdle  = 1'b0,
        eMerge = 1'b1
    } rmw_state_e;

    // One write-mask bit widens to the eight data bits it governs
    function automatic logic [7:0] expand_mask_bit(input logic m);
        return m ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// Plain single-port synchronous RAM: one read or one write per cycle, read data a cycle later.
module bsg_mem_1rw_sync #(
    parameter int width_p           = 32,
    parameter int els_p             = 64,
    parameter int latch_last_read_p = 0,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic                     v_i,
    input  logic                     w_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem_r [els_p];
    logic [width_p-1:0] data_r;

    // storage array write port, contents intentionally not reset
    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            mem_r[addr_i] <= data_i;
        end
    end

    // registered read port; without last-read latching, a write clears the stale word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r <= '0;
        end else if (v_i & ~w_i) begin
            data_r <= mem_r[addr_i];
        end else if ((latch_last_read_p == 0) && v_i) begin
            data_r <= '0;
        end else begin
            data_r <= data_r;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_rmw_chk.sv
// Protocol and parameter checks for the masked RMW RAM.
module bsg_mem_1rw_sync_mask_rmw_chk #(
    parameter int width_p       = 32,
    parameter int els_p         = 64,
    parameter int addr_width_lp = 6
) (
    input logic                     clk_i,
    input logic                     reset_n_i,
    input logic                     v_i,
    input logic                     ready_o,
    input logic [addr_width_lp-1:0] addr_i,
    input logic                     v_o,
    input logic                     yumi_i
);

    a_addr_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (v_i & ready_o) |-> (int'(addr_i) < els_p));

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_o);

    a_width_bytes: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (width_p % 8) == 0);

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_rmw.sv
// Byte-masked single-port RAM built on an unmasked array; partial writes take a read then a merge write.
module bsg_mem_1rw_sync_mask_rmw
    import bsg_mem_rmw_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int els_p             = 64,
    parameter int latch_last_read_p = 1,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int mask_width_lp    = width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] w_mask_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i
);

    rmw_state_e               state_r, state_next_s;
    logic [addr_width_lp-1:0] addr_r;
    logic [width_p-1:0]       wdata_r;
    logic [mask_width_lp-1:0] mask_r;
    logic                     v_r, first_r;
    logic [width_p-1:0]       hold_r;

    logic                     accept_s, full_s, zero_s, rd_s, partial_s;
    logic                     mem_v_s, mem_w_s;
    logic [addr_width_lp-1:0] mem_addr_s;
    logic [width_p-1:0]       mem_wdata_s, mem_rdata_s, bytemask_s, merged_s;

    assign ready_o   = (state_r == eIdle) & (~v_r | yumi_i);
    assign accept_s  = v_i & ready_o;
    assign full_s    = &w_mask_i;
    assign zero_s    = ~|w_mask_i;
    assign rd_s      = accept_s & ~w_i;
    assign partial_s = accept_s & w_i & ~full_s & ~zero_s;

    for (genvar k = 0; k < mask_width_lp; k++) begin : g_mask
        assign bytemask_s[8*k +: 8] = expand_mask_bit(mask_r[k]);
    end

    // the old word arrives from the array in the merge cycle
    assign merged_s = (mem_rdata_s & ~bytemask_s) | (wdata_r & bytemask_s);

    // state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= eIdle;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state: a partial write detours through one merge cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            eIdle:   state_next_s = partial_s ? eMerge : eIdle;
            eMerge:  state_next_s = eIdle;
            default: state_next_s = eIdle;
        endcase
    end

    // array port mux: live request when idle, latched merge write otherwise
    always_comb begin
        mem_v_s     = 1'b0;
        mem_w_s     = 1'b0;
        mem_addr_s  = addr_i;
        mem_wdata_s = data_i;
        case (state_r)
            eIdle: begin
                mem_v_s = accept_s & (~w_i | ~zero_s);
                mem_w_s = w_i & full_s;
            end
            eMerge: begin
                mem_v_s     = 1'b1;
                mem_w_s     = 1'b1;
                mem_addr_s  = addr_r;
                mem_wdata_s = merged_s;
            end
            default: begin
                mem_v_s = 1'b0;
                mem_w_s = 1'b0;
            end
        endcase
    end

    // partial-write operands held for the merge cycle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_r  <= '0;
            wdata_r <= '0;
            mask_r  <= '0;
        end else if (partial_s) begin
            addr_r  <= addr_i;
            wdata_r <= data_i;
            mask_r  <= w_mask_i;
        end
    end

    // response slot: filled by a read accept, emptied by yumi
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r     <= 1'b0;
            first_r <= 1'b0;
        end else begin
            v_r     <= rd_s | (v_r & ~yumi_i);
            first_r <= rd_s;
        end
    end

    // hold register keeps the word once the array output moves on
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_r <= '0;
        end else if (first_r) begin
            hold_r <= mem_rdata_s;
        end else if ((latch_last_read_p == 0) && yumi_i) begin
            hold_r <= '0;
        end else begin
            hold_r <= hold_r;
        end
    end

    assign v_o    = v_r;
    assign data_o = first_r ? mem_rdata_s : hold_r;

    bsg_mem_1rw_sync #(
        .width_p           (width_p),
        .els_p             (els_p),
        .latch_last_read_p (0)
    ) mem (
        .clk_i   (clk_i),
        .reset_i (~reset_n_i),
        .data_i  (mem_wdata_s),
        .addr_i  (mem_addr_s),
        .v_i     (mem_v_s & reset_n_i),
        .w_i     (mem_w_s),
        .data_o  (mem_rdata_s)
    );

    bsg_mem_1rw_sync_mask_rmw_chk #(
        .width_p       (width_p),
        .els_p         (els_p),
        .addr_width_lp (addr_width_lp)
    ) chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .addr_i    (addr_i),
        .v_o       (v_o),
        .yumi_i    (yumi_i)
    );

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_rmw.sv
// Scoreboard bench: directed scenarios plus random traffic against a word-array model.
module tb_bsg_mem_1rw_sync_mask_rmw;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        v_i = 1'b0, w_i = 1'b0, yumi_i = 1'b0;
    logic [5:0]  addr_i = 6'd0;
    logic [31:0] data_i = 32'd0;
    logic [3:0]  w_mask_i = 4'd0;
    logic        ready_o, v_o;
    logic [31:0] data_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [64];
    logic [31:0] exp_q [$];

    bsg_mem_1rw_sync_mask_rmw #(.width_p(32), .els_p(64), .latch_last_read_p(1)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
        .addr_i(addr_i), .data_i(data_i), .w_mask_i(w_mask_i), .v_o(v_o), .data_o(data_o),
        .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change #1 after posedge, acceptance is judged at negedge.
    task automatic cycle(input logic v, input logic w, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic yu, output logic acc, output logic rdy);
        v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m;
        yumi_i = yu & v_o;
        @(negedge clk_i);
        rdy = ready_o;
        acc = v & ready_o;
        if (acc && w) begin
            for (int k = 0; k < 4; k++)
                if (m[k]) model[a][8*k +: 8] = d[8*k +: 8];
        end else if (acc) begin
            exp_q.push_back(model[a]);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: a consumed response must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        if (reset_n_i && v_o && yumi_i) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                check("resp_data", data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic acc, rdy;
        logic [31:0] old7, val;
        logic [3:0] m;

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ready", {31'd0, ready_o}, 32'd1);
        check("reset_v_o", {31'd0, v_o}, 32'd0);
        check("reset_data_o", data_o, 32'd0);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // preload every word with full writes
        for (int i = 0; i < 64; i++) begin
            val = (i == 5) ? 32'hDEADBEEF : (i == 3) ? 32'h0 : ($urandom() | 32'h1);
            cycle(1'b1, 1'b1, 6'(i), val, 4'hF, 1'b0, acc, rdy);
            check("preload_acc", {31'd0, acc}, 32'd1);
        end
        check("full_write_ready", {31'd0, ready_o}, 32'd1);

        // read 5: response one cycle after accept
        cycle(1'b1, 1'b0, 6'd5, 32'd0, 4'h0, 1'b0, acc, rdy);
        check("read5_v_o", {31'd0, v_o}, 32'd1);
        check("read5_data", data_o, 32'hDEADBEEF);
        cycle(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1, acc, rdy);
        check("read5_consumed", {31'd0, v_o}, 32'd0);

        // partial write stalls exactly one cycle
        cycle(1'b1, 1'b1, 6'd5, 32'h11223344, 4'b0101, 1'b0, acc, rdy);
        check("partial_acc", {31'd0, acc}, 32'd1);
        check("merge_ready_low", {31'd0, ready_o}, 32'd0);
        cycle(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b0, acc, rdy);
        check("merge_ready_back", {31'd0, ready_o}, 32'd1);
        cycle(1'b1, 1'b0, 6'd5, 32'd0, 4'h0, 1'b0, acc, rdy);
        check("merged_data", data_o, 32'hDE22BE44);

        // hold response with yumi low for four cycles
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 6'd1, 32'd0, 4'h0, 1'b0, acc, rdy);
            check("hold_no_accept", {31'd0, acc}, 32'd0);
            check("hold_ready", {31'd0, ready_o}, 32'd0);
            check("hold_data", data_o, 32'hDE22BE44);
        end
        cycle(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1, acc, rdy);
        check("yumi_ready_same_cycle", {31'd0, rdy}, 32'd1);

        // streaming reads with yumi held high
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 6'(i), 32'd0, 4'h0, 1'b1, acc, rdy);
            check("stream_acc", {31'd0, acc}, 32'd1);
        end
        cycle(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1, acc, rdy);

        // zero-mask write is accepted but changes nothing
        cycle(1'b1, 1'b1, 6'd3, 32'hFFFFFFFF, 4'h0, 1'b0, acc, rdy);
        check("zero_mask_acc", {31'd0, acc}, 32'd1);
        check("zero_mask_ready", {31'd0, ready_o}, 32'd1);
        cycle(1'b1, 1'b0, 6'd3, 32'd0, 4'h0, 1'b0, acc, rdy);
        check("zero_mask_data", data_o, 32'h0);
        cycle(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1, acc, rdy);

        // reset during the merge cycle aborts the write
        old7 = model[7];
        cycle(1'b1, 1'b0, 6'd7, 32'd0, 4'h0, 1'b0, acc, rdy);
        cycle(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1, acc, rdy);
        check("hold_last_read", data_o, old7);
        cycle(1'b1, 1'b1, 6'd7, ~old7, 4'b0011, 1'b0, acc, rdy);
        check("rmw_reset_in_merge", {31'd0, ready_o}, 32'd0);
        v_i = 1'b0;
        reset_n_i = 1'b0;
        #1;
        check("async_reset_ready", {31'd0, ready_o}, 32'd1);
        check("async_reset_v_o", {31'd0, v_o}, 32'd0);
        check("async_reset_data", data_o, 32'd0);
        model[7] = old7;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cycle(1'b1, 1'b0, 6'd7, 32'd0, 4'h0, 1'b0, acc, rdy);
        check("aborted_merge_data", data_o, old7);
        cycle(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1, acc, rdy);

        // random mixed traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(3, 0))
                0:       m = 4'h0;
                1:       m = 4'hF;
                default: m = 4'($urandom());
            endcase
            cycle(($urandom_range(3, 0) != 0), 1'($urandom()), 6'($urandom()), $urandom(), m,
                  ($urandom_range(2, 0) != 0), acc, rdy);
        end
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1, acc, rdy);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
